// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT sequencer.
// Holds the state encoding, default sizing and the bit-reverse helper.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    DRAIN,
    UNLOAD
  } state_e;

  localparam int N_LOG2_DEF = 8;
  localparam int BF_LAT_DEF = 4;
  localparam int BITREV_MAX = 16;

  // Reverse the low w bits of v; upper bits of the result are zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(
    input logic [BITREV_MAX-1:0] v,
    input int                    w
  );
    logic [BITREV_MAX-1:0] full;
    full = {<<{v}};
    return full >> (BITREV_MAX - w);
  endfunction

endpackage

// File: rtl/fft_idx_counter.sv
// Enable-gated up-counter with a programmable terminal value.
// Wraps to zero after the terminal count; tc flags the terminal value.
module fft_idx_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tc    = (cnt_q == term);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the radix-2 DIF FFT core: load, butterfly
// stages with pipeline drain, then bit-reversed unload.
module fft_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      wr_en,
  output logic [N_LOG2-1:0]         wr_addr,
  output logic                      bf_en,
  output logic [N_LOG2-1:0]         bf_addr_a,
  output logic [N_LOG2-1:0]         bf_addr_b,
  output logic [N_LOG2-2:0]         tw_idx,
  output logic [$clog2(N_LOG2)-1:0] stage,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [N_LOG2-1:0]         rd_addr,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int W  = N_LOG2;
  localparam int KW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2);

  localparam logic [W-1:0]  N_TERM = '1;
  localparam logic [KW-1:0] K_TERM = '1;
  localparam logic [SW-1:0] S_TERM = SW'(N_LOG2 - 1);
  localparam logic [3:0]    D_TERM =
    4'(BF_LAT == 0 ? 0 : BF_LAT - 1);

  state_e state_q, state_d;
  logic   done_q, done_d;

  logic [W-1:0]  nm;
  logic [KW-1:0] k;
  logic [SW-1:0] stg;
  logic [3:0]    drain_unused;
  logic nm_tc, k_tc, s_tc, d_tc;
  logic nm_en, k_en, s_en, d_en;

  logic [SW-1:0] sh;
  logic [W-1:0]  kw, msk, j, g, a, span;

  fft_idx_counter #(.W(W)) u_nm (
    .clk(clk), .rst(rst), .en(nm_en),
    .term(N_TERM), .cnt(nm), .tc(nm_tc)
  );

  fft_idx_counter #(.W(KW)) u_k (
    .clk(clk), .rst(rst), .en(k_en),
    .term(K_TERM), .cnt(k), .tc(k_tc)
  );

  fft_idx_counter #(.W(4)) u_drain (
    .clk(clk), .rst(rst), .en(d_en),
    .term(D_TERM), .cnt(drain_unused), .tc(d_tc)
  );

  fft_idx_counter #(.W(SW)) u_stage (
    .clk(clk), .rst(rst), .en(s_en),
    .term(S_TERM), .cnt(stg), .tc(s_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_en    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = LOAD;
      LOAD:   if (in_valid && nm_tc) state_d = CALC;
      CALC: begin
        if (k_tc) begin
          if (BF_LAT != 0) begin
            state_d = DRAIN;
          end else begin
            s_en    = 1'b1;
            state_d = s_tc ? UNLOAD : CALC;
          end
        end
      end
      DRAIN: begin
        if (d_tc) begin
          s_en    = 1'b1;
          state_d = s_tc ? UNLOAD : CALC;
        end
      end
      UNLOAD: begin
        if (out_ready && nm_tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Butterfly pair: group g of width 2*span, offset j inside it.
  always_comb begin
    sh   = S_TERM - stg;
    kw   = W'(k);
    span = W'(1) << sh;
    msk  = span - W'(1);
    j    = kw & msk;
    g    = kw >> sh;
    a    = ((g << sh) << 1) | j;
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    bf_en     = (state_q == CALC);
    out_valid = (state_q == UNLOAD);
    busy      = (state_q != IDLE);
    wr_en     = in_ready & in_valid;
    wr_addr   = in_ready ? nm : '0;
    bf_addr_a = bf_en ? a : '0;
    bf_addr_b = bf_en ? a + span : '0;
    tw_idx    = bf_en ? KW'(j << stg) : '0;
    stage     = stg;
    rd_addr   = out_valid ?
      W'(bitrev(BITREV_MAX'(nm), W)) : '0;
    out_last  = out_valid & nm_tc;
    done      = done_q;
    nm_en     = wr_en | (out_valid & out_ready);
    k_en      = bf_en;
    d_en      = (state_q == DRAIN);
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: a frame-level model fills queues,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_fft_seq_ctrl;
  import fft_ctrl_pkg::*;

  localparam int NL = 8;
  localparam int N  = 256;
  localparam int BL = 4;

  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic use0 = 0;
  wire  start0 = start & use0;

  logic          in_ready, wr_en, bf_en, out_valid;
  logic          out_last, busy, done;
  logic [NL-1:0] wr_addr, bf_addr_a, bf_addr_b, rd_addr;
  logic [NL-2:0] tw_idx;
  logic [2:0]    stage;

  logic          in_ready0, wr_en0, bf_en0, out_valid0;
  logic          out_last0, busy0, done0;
  logic [NL-1:0] wr_addr0, bf_addr_a0, bf_addr_b0, rd_addr0;
  logic [NL-2:0] tw_idx0;
  logic [2:0]    stage0;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.N_LOG2(NL), .BF_LAT(BL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .bf_en(bf_en), .bf_addr_a(bf_addr_a),
    .bf_addr_b(bf_addr_b), .tw_idx(tw_idx),
    .stage(stage), .out_ready(out_ready),
    .out_valid(out_valid), .rd_addr(rd_addr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  fft_seq_ctrl #(.N_LOG2(NL), .BF_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .in_valid(in_valid), .in_ready(in_ready0),
    .wr_en(wr_en0), .wr_addr(wr_addr0),
    .bf_en(bf_en0), .bf_addr_a(bf_addr_a0),
    .bf_addr_b(bf_addr_b0), .tw_idx(tw_idx0),
    .stage(stage0), .out_ready(out_ready),
    .out_valid(out_valid0), .rd_addr(rd_addr0),
    .out_last(out_last0), .busy(busy0), .done(done0)
  );

  typedef struct {
    int a;
    int b;
    int tw;
    int s;
    int k;
  } bf_t;

  int  exp_wr[$];
  bf_t exp_bf[$];
  int  exp_rd[$];

  int checks = 0;
  int errors = 0;
  int exp_busy = 0;
  int busy_cnt = 0;
  int gap = 0;
  int done_cnt = 0;
  bit first_rd = 0;
  bit done_prev = 0;
  int b0 = 0;
  int run0 = 0;
  int maxrun0 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d expected=none", nm, act);
  endtask

  function automatic int rev(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < NL; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return rev_ret(r);
  endfunction

  function automatic int rev_ret(input int r);
    return r;
  endfunction

  task automatic push_frame();
    for (int n = 0; n < N; n++) exp_wr.push_back(n);
    for (int s = 0; s < NL; s++) begin
      for (int k = 0; k < N / 2; k++) begin
        bf_t e;
        int  span;
        span = N / (2 ** (s + 1));
        e.a  = (k / span) * 2 * span + (k % span);
        e.b  = e.a + span;
        e.tw = (k % span) * (2 ** s);
        e.s  = s;
        e.k  = k;
        exp_bf.push_back(e);
      end
    end
    for (int m = 0; m < N; m++) exp_rd.push_back(rev(m));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (in_ready && exp_wr.size() == 0) bad("in_ready_extra", 1);
      if (wr_en) begin
        if (exp_wr.size() == 0) bad("wr_unexpected", wr_addr);
        else chk("wr_addr", wr_addr, exp_wr.pop_front());
        gap = 0;
      end
      if (bf_en) begin
        if (exp_bf.size() == 0) begin
          bad("bf_unexpected", bf_addr_a);
        end else begin
          bf_t e;
          e = exp_bf.pop_front();
          chk("bf_addr_a", bf_addr_a, e.a);
          chk("bf_addr_b", bf_addr_b, e.b);
          chk("tw_idx", tw_idx, e.tw);
          chk("stage", stage, e.s);
          chk("bf_gap", gap, (e.k == 0 && e.s > 0) ? BL : 0);
        end
        gap = 0;
        first_rd = 1;
      end
      if (out_valid) begin
        if (first_rd) begin
          chk("unload_gap", gap, BL);
          first_rd = 0;
        end
        if (exp_rd.size() == 0) begin
          bad("rd_unexpected", rd_addr);
        end else if (out_ready) begin
          chk("out_last", out_last, exp_rd.size() == 1);
          chk("rd_addr", rd_addr, exp_rd.pop_front());
        end else begin
          chk("rd_hold", rd_addr, exp_rd[0]);
        end
      end
      if (!wr_en && !bf_en && !out_valid) gap++;
      if (done) begin
        done_cnt++;
        if (done_prev) bad("done_long", 1);
        if (exp_busy > 0) chk("busy_cycles", busy_cnt, exp_busy);
        chk("queues_left",
            exp_wr.size() + exp_bf.size() + exp_rd.size(), 0);
        busy_cnt = 0;
      end
      done_prev = done;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (busy0) b0++;
      if (bf_en0) begin
        run0++;
      end else if (run0 > 0) begin
        if (run0 > maxrun0) maxrun0 = run0;
        run0 = 0;
      end
      if (done0) begin
        chk("lat0_busy", b0, 2 * N + NL * N / 2);
        chk("lat0_bf_run", maxrun0, NL * N / 2);
        b0 = 0;
      end
    end
  end

  task automatic run_frame(
    input int mode, input int busy_exp, input bit poke
  );
    int d, hs, stall;
    push_frame();
    exp_busy = busy_exp;
    d = done_cnt;
    hs = 0;
    stall = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 20000 && done_cnt == d; i++) begin
      start = poke && (i == 400);
      case (mode)
        0: begin
          in_valid  = 1;
          out_ready = 1;
        end
        1: begin
          in_valid  = (i % 2 == 0);
          out_ready = !(hs == 10 && stall < 5);
        end
        default: begin
          in_valid  = ($urandom_range(0, 2) != 0);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      endcase
      #2;
      if (out_valid && out_ready) begin
        hs++;
      end else if (mode == 1 && hs == 10 && out_valid) begin
        stall++;
        chk("rd_hold_m10", rd_addr, rev(10));
      end
      @(negedge clk);
    end
    start = 0;
    if (done_cnt == d) bad("done_timeout", done_cnt);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bf_en", bf_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_stage", stage, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    use0 = 1;
    run_frame(0, 2 * N + NL * (N / 2 + BL), 0);
    use0 = 0;
    repeat (3) @(negedge clk);
    chk("idle_after_done", busy, 0);

    run_frame(1, 0, 0);
    repeat (3) @(negedge clk);

    run_frame(0, 2 * N + NL * (N / 2 + BL), 1);
    repeat (5) @(negedge clk);
    chk("start_in_calc_ignored", busy, 0);

    push_frame();
    exp_busy = 0;
    @(negedge clk);
    start = 1;
    in_valid = 1;
    out_ready = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 3000 && !(bf_en && stage == 3); i++)
      @(negedge clk);
    if (!(bf_en && stage == 3)) bad("stage3_timeout", stage);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bf_en", bf_en, 0);
    chk("mid_rst_addr_a", bf_addr_a, 0);
    chk("mid_rst_addr_b", bf_addr_b, 0);
    chk("mid_rst_tw", tw_idx, 0);
    chk("mid_rst_stage", stage, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    exp_wr.delete();
    exp_bf.delete();
    exp_rd.delete();
    busy_cnt = 0;
    gap = 0;
    first_rd = 0;
    d0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("no_done_after_rst", done_cnt, d0);

    run_frame(0, 2 * N + NL * (N / 2 + BL), 0);
    repeat (3) @(negedge clk);
    run_frame(2, 0, 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
